// File: rtl/sync_bidir_fifo.sv
// sync_bidir_fifo
// Single-clock FIFO shared by two ports, A and B, that take turns on a
// half-duplex channel. One port writes and the other reads. The direction
// is changed at runtime with a request/acknowledge handshake. Before the
// direction flips, the FIFO drains completely and both pointers return to
// zero.
//
// Ports:
//   clk, rst_n          single rising-edge clock; synchronous active-low reset
//   a_winc/a_wdata      port A write strobe / data (used while dir=1)
//   a_rinc/a_rdata      port A read strobe / data (used while dir=0)
//   a_full/a_afull      port A writer flags (held at 1 while A is the reader)
//   a_empty/a_aempty    port A reader flags (held at 1 while A is the writer)
//   b_*                 mirror of the A port, active in the opposite direction
//   dir_req_valid       direction-change request strobe
//   dir_req             requested direction (1 = A->B, 0 = B->A)
//   dir_ack             one-cycle pulse once the requested direction is active
//   dir                 current direction, same encoding as dir_req
//   count               current occupancy, 0..DEPTH
module sync_bidir_fifo #(
   parameter int    DSIZE       = 8,
   parameter int    ASIZE       = 4,
   parameter int    AFULL_GAP   = 1,
   parameter int    AEMPTY_GAP  = 1,
   parameter string FALLTHROUGH = "TRUE"
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_winc,
   input  logic [DSIZE-1:0] a_wdata,
   input  logic             a_rinc,
   output logic [DSIZE-1:0] a_rdata,
   output logic             a_full,
   output logic             a_afull,
   output logic             a_empty,
   output logic             a_aempty,
   input  logic             b_winc,
   input  logic [DSIZE-1:0] b_wdata,
   input  logic             b_rinc,
   output logic [DSIZE-1:0] b_rdata,
   output logic             b_full,
   output logic             b_afull,
   output logic             b_empty,
   output logic             b_aempty,
   input  logic             dir_req_valid,
   input  logic             dir_req,
   output logic             dir_ack,
   output logic             dir,
   output logic [ASIZE:0]   count
);

   localparam int             DEPTH      = 1 << ASIZE;
   localparam logic [ASIZE:0] DEPTH_LVL  = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AFULL_LVL  = (ASIZE+1)'(DEPTH - AFULL_GAP);
   localparam logic [ASIZE:0] AEMPTY_LVL = (ASIZE+1)'(AEMPTY_GAP);
   localparam bit             FWFT       = (FALLTHROUGH == "TRUE");

   localparam logic [1:0] RUN_A2B  = 2'd0;
   localparam logic [1:0] TURN_B2A = 2'd1;
   localparam logic [1:0] RUN_B2A  = 2'd2;
   localparam logic [1:0] TURN_A2B = 2'd3;

   logic [1:0]       state_q,   state_d;
   logic [ASIZE:0]   count_q,   count_d;
   logic [ASIZE-1:0] wptr_q,    wptr_d;
   logic [ASIZE-1:0] rptr_q,    rptr_d;
   logic             dir_ack_q, dir_ack_d;
   logic [DSIZE-1:0] rdata_q,   rdata_d;
   logic [DSIZE-1:0] mem_q [DEPTH];

   logic             dir_s;
   logic             turning_s;
   logic             w_full_s, w_afull_s, r_empty_s, r_aempty_s;
   logic             w_inc_s, r_inc_s, wr_en_s, rd_en_s;
   logic [DSIZE-1:0] w_data_s, rd_word_s, rdata_out_s;

   // A TURN state still reports the old direction until the drain completes.
   assign dir_s     = (state_q == RUN_A2B) || (state_q == TURN_B2A);
   assign turning_s = (state_q == TURN_B2A) || (state_q == TURN_A2B);

   // Flags come only from registered state, so a read on the same cycle
   // cannot free a slot for a write while the FIFO is full.
   assign w_full_s   = (count_q == DEPTH_LVL) || turning_s;
   assign w_afull_s  = (count_q >= AFULL_LVL) || turning_s;
   assign r_empty_s  = (count_q == '0);
   assign r_aempty_s = (count_q <= AEMPTY_LVL);

   assign w_inc_s  = dir_s ? a_winc  : b_winc;
   assign w_data_s = dir_s ? a_wdata : b_wdata;
   assign r_inc_s  = dir_s ? b_rinc  : a_rinc;
   assign wr_en_s  = w_inc_s && !w_full_s;
   assign rd_en_s  = r_inc_s && !r_empty_s;

   assign rd_word_s   = mem_q[rptr_q];
   assign rdata_out_s = FWFT ? rd_word_s : rdata_q;

   assign a_full   = dir_s ? w_full_s   : 1'b1;
   assign a_afull  = dir_s ? w_afull_s  : 1'b1;
   assign a_empty  = dir_s ? 1'b1       : r_empty_s;
   assign a_aempty = dir_s ? 1'b1       : r_aempty_s;
   assign b_full   = dir_s ? 1'b1       : w_full_s;
   assign b_afull  = dir_s ? 1'b1       : w_afull_s;
   assign b_empty  = dir_s ? r_empty_s  : 1'b1;
   assign b_aempty = dir_s ? r_aempty_s : 1'b1;
   assign a_rdata  = dir_s ? '0 : rdata_out_s;
   assign b_rdata  = dir_s ? rdata_out_s : '0;
   assign dir      = dir_s;
   assign dir_ack  = dir_ack_q;
   assign count    = count_q;

   // Next-state logic: pointers, occupancy, read register and direction FSM.
   always_comb begin
      state_d   = state_q;
      dir_ack_d = 1'b0;
      wptr_d    = wr_en_s ? (wptr_q + ASIZE'(1)) : wptr_q;
      rptr_d    = rd_en_s ? (rptr_q + ASIZE'(1)) : rptr_q;
      rdata_d   = rd_en_s ? rd_word_s : rdata_q;
      case ({wr_en_s, rd_en_s})
         2'b10:   count_d = count_q + (ASIZE+1)'(1);
         2'b01:   count_d = count_q - (ASIZE+1)'(1);
         default: count_d = count_q;
      endcase
      case (state_q)
         RUN_A2B: begin
            if (dir_req_valid) begin
               if (dir_req) begin
                  dir_ack_d = 1'b1;
               end else begin
                  state_d = TURN_B2A;
               end
            end else begin
               state_d = RUN_A2B;
            end
         end
         RUN_B2A: begin
            if (dir_req_valid) begin
               if (!dir_req) begin
                  dir_ack_d = 1'b1;
               end else begin
                  state_d = TURN_A2B;
               end
            end else begin
               state_d = RUN_B2A;
            end
         end
         TURN_B2A, TURN_A2B: begin
            // Writes are blocked here, so count==0 means the drain is done.
            if (count_q == '0) begin
               state_d   = (state_q == TURN_B2A) ? RUN_B2A : RUN_A2B;
               dir_ack_d = 1'b1;
               wptr_d    = '0;
               rptr_d    = '0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = RUN_A2B;
         end
      endcase
   end

   // Control and status registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= RUN_A2B;
         count_q   <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         dir_ack_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         dir_ack_q <= dir_ack_d;
         rdata_q   <= rdata_d;
      end
   end

   // Storage array; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wptr_q] <= w_data_s;
      end
   end

endmodule

// File: tb/tb_sync_bidir_fifo.sv
module tb_sync_bidir_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_winc, a_rinc, b_winc, b_rinc, dir_req_valid, dir_req;
   logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata;
   logic       a_full, a_afull, a_empty, a_aempty;
   logic       b_full, b_afull, b_empty, b_aempty;
   logic       dir_ack, dir;
   logic [4:0] count;

   // second instance, registered read
   logic       r_a_winc, r_b_rinc;
   logic [7:0] r_a_wdata, r_a_rdata, r_b_rdata;
   logic       r_a_full, r_a_afull, r_a_empty, r_a_aempty;
   logic       r_b_full, r_b_afull, r_b_empty, r_b_aempty;
   logic       r_dir_ack, r_dir;
   logic [4:0] r_count;

   int         n_asserts = 0;
   int         n_fails   = 0;
   logic [7:0] sb[$];
   bit         m_dir  = 1'b1;
   bit         m_turn = 1'b0;

   always #5 clk = ~clk;

   sync_bidir_fifo #(.DSIZE(8), .ASIZE(4), .AFULL_GAP(1), .AEMPTY_GAP(1), .FALLTHROUGH("TRUE")) dut (
      .clk(clk), .rst_n(rst_n),
      .a_winc(a_winc), .a_wdata(a_wdata), .a_rinc(a_rinc), .a_rdata(a_rdata),
      .a_full(a_full), .a_afull(a_afull), .a_empty(a_empty), .a_aempty(a_aempty),
      .b_winc(b_winc), .b_wdata(b_wdata), .b_rinc(b_rinc), .b_rdata(b_rdata),
      .b_full(b_full), .b_afull(b_afull), .b_empty(b_empty), .b_aempty(b_aempty),
      .dir_req_valid(dir_req_valid), .dir_req(dir_req), .dir_ack(dir_ack),
      .dir(dir), .count(count)
   );

   sync_bidir_fifo #(.DSIZE(8), .ASIZE(4), .AFULL_GAP(1), .AEMPTY_GAP(1), .FALLTHROUGH("FALSE")) dut_r (
      .clk(clk), .rst_n(rst_n),
      .a_winc(r_a_winc), .a_wdata(r_a_wdata), .a_rinc(1'b0), .a_rdata(r_a_rdata),
      .a_full(r_a_full), .a_afull(r_a_afull), .a_empty(r_a_empty), .a_aempty(r_a_aempty),
      .b_winc(1'b0), .b_wdata(8'h00), .b_rinc(r_b_rinc), .b_rdata(r_b_rdata),
      .b_full(r_b_full), .b_afull(r_b_afull), .b_empty(r_b_empty), .b_aempty(r_b_aempty),
      .dir_req_valid(1'b0), .dir_req(1'b0), .dir_ack(r_dir_ack),
      .dir(r_dir), .count(r_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // write one word from port A (side_a=1) or B; the scoreboard keeps it if it should be accepted
   task automatic wr(input bit side_a, input logic [7:0] d);
      if (side_a) begin a_winc = 1'b1; a_wdata = d; end
      else        begin b_winc = 1'b1; b_wdata = d; end
      if (!m_turn && (m_dir == side_a) && (sb.size() < 16)) sb.push_back(d);
      step();
      a_winc = 1'b0;
      b_winc = 1'b0;
   endtask

   // read one word on port A (side_a=1) or B, comparing against the scoreboard head
   task automatic rd(input bit side_a);
      logic [7:0] obs;
      obs = side_a ? a_rdata : b_rdata;
      if ((m_dir != side_a) && (sb.size() > 0)) check("rdata", {24'h0, obs}, {24'h0, sb[0]});
      if (side_a) a_rinc = 1'b1; else b_rinc = 1'b1;
      step();
      a_rinc = 1'b0;
      b_rinc = 1'b0;
      if ((m_dir != side_a) && (sb.size() > 0)) void'(sb.pop_front());
   endtask

   task automatic req(input bit d);
      dir_req_valid = 1'b1;
      dir_req       = d;
      step();
      dir_req_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      a_winc = 1'b0; a_rinc = 1'b0; b_winc = 1'b0; b_rinc = 1'b0;
      a_wdata = 8'h00; b_wdata = 8'h00; dir_req_valid = 1'b0; dir_req = 1'b0;
      r_a_winc = 1'b0; r_b_rinc = 1'b0; r_a_wdata = 8'h00;
      step();
      step();
      rst_n = 1'b1;

      // reset state
      check("rst_count", 32'(count), 32'd0);
      check("rst_dir", 32'(dir), 32'd1);
      check("rst_flags", {24'h0, a_full, a_afull, a_empty, a_aempty, b_full, b_afull, b_empty, b_aempty},
            32'b0011_1111);
      check("rst_ack", 32'(dir_ack), 32'd0);
      check("rst_r_rdata", 32'(r_b_rdata), 32'd0);

      // fill 16 words, almost-full from 15, almost-empty at <=1
      for (int i = 0; i < 16; i++) begin
         wr(1'b1, 8'(i));
         check("fill_afull", 32'(a_afull), 32'(sb.size() >= 15));
         check("fill_baempty", 32'(b_aempty), 32'(sb.size() <= 1));
      end
      check("full_a", 32'(a_full), 32'd1);
      check("full_count", 32'(count), 32'd16);
      wr(1'b1, 8'hEE);
      check("overfill_count", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) rd(1'b0);
      check("drain_bempty", 32'(b_empty), 32'd1);
      check("drain_count", 32'(count), 32'd0);
      rd(1'b0);
      check("underflow_count", 32'(count), 32'd0);

      // wrap with concurrent traffic
      for (int i = 0; i < 10; i++) wr(1'b1, 8'(8'h20 + i));
      for (int i = 0; i < 6; i++) rd(1'b0);
      for (int i = 0; i < 12; i++) wr(1'b1, 8'(8'h40 + i));
      check("wrap_count16", 32'(count), 32'd16);
      for (int i = 0; i < 8; i++) rd(1'b0);
      check("wrap_count8", 32'(count), 32'd8);
      check("simul_rdata", 32'(b_rdata), 32'(sb[0]));
      a_winc = 1'b1; a_wdata = 8'h77; b_rinc = 1'b1;
      step();
      a_winc = 1'b0; b_rinc = 1'b0;
      void'(sb.pop_front());
      sb.push_back(8'h77);
      check("simul_count", 32'(count), 32'd8);
      for (int i = 0; i < 8; i++) rd(1'b0);
      check("wrap_empty", 32'(b_empty), 32'd1);

      // turn with backlog
      for (int i = 0; i < 3; i++) wr(1'b1, 8'(8'h90 + i));
      req(1'b0);
      m_turn = 1'b1;
      check("turn_afull", 32'(a_full), 32'd1);
      check("turn_dir_old", 32'(dir), 32'd1);
      wr(1'b1, 8'hBB);
      check("turn_wr_blocked", 32'(count), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("turn_no_ack", 32'(dir_ack), 32'd0);
         rd(1'b0);
      end
      check("turn_still_old", 32'(dir), 32'd1);
      step();
      m_turn = 1'b0;
      m_dir  = 1'b0;
      check("turn_ack", 32'(dir_ack), 32'd1);
      check("turn_dir_new", 32'(dir), 32'd0);
      check("turn_count", 32'(count), 32'd0);
      step();
      check("turn_ack_pulse", 32'(dir_ack), 32'd0);
      check("b2a_flags", {28'h0, a_full, b_full, a_empty, b_empty}, 32'b1011);
      wr(1'b0, 8'h55);
      rd(1'b1);
      check("b2a_empty", 32'(a_empty), 32'd1);

      // turn back while empty: ack two cycles after request
      req(1'b1);
      check("back_ack0", 32'(dir_ack), 32'd0);
      check("back_bfull", 32'(b_full), 32'd1);
      step();
      m_dir = 1'b1;
      check("back_ack1", 32'(dir_ack), 32'd1);
      check("back_dir", 32'(dir), 32'd1);

      // same-direction request
      step();
      req(1'b1);
      check("same_ack", 32'(dir_ack), 32'd1);
      check("same_dir", 32'(dir), 32'd1);
      check("same_afull", 32'(a_full), 32'd0);
      step();
      check("same_ack_pulse", 32'(dir_ack), 32'd0);

      // registered-read variant
      r_a_winc = 1'b1; r_a_wdata = 8'hA5;
      step();
      r_a_winc = 1'b0;
      check("r_before_read", 32'(r_b_rdata), 32'd0);
      r_b_rinc = 1'b1;
      step();
      r_b_rinc = 1'b0;
      check("r_after_read", 32'(r_b_rdata), 32'hA5);

      // abort a turn with reset
      wr(1'b1, 8'h11);
      wr(1'b1, 8'h12);
      req(1'b0);
      check("abort_turning", 32'(a_full), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      sb.delete();
      m_turn = 1'b0;
      m_dir  = 1'b1;
      check("abort_dir", 32'(dir), 32'd1);
      check("abort_count", 32'(count), 32'd0);
      check("abort_afull", 32'(a_full), 32'd0);
      check("abort_r_rdata", 32'(r_b_rdata), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("abort_no_ack", 32'(dir_ack), 32'd0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
